// File: rtl/fwd_hazard_sb_if.sv
// fwd_hazard_sb_if: signal bundle between the EXE stage and the forwarding/hazard scoreboard.
// Ports:
//   rd_addr_i   [NUM_RD*REG_AW]          EXE source register addresses, port 0 in LSBs
//   rd_en_i     [NUM_RD]                 port actually reads the GPR
//   hilo_rd_i   [1]                      EXE instruction reads HI or LO
//   st_wr_i     [NUM_FWD_STAGES]         stage k writes the GPR
//   st_dst_i    [NUM_FWD_STAGES*REG_AW]  stage k destination register
//   st_rdy_i    [NUM_FWD_STAGES]         stage k result valid this cycle
//   md_start_i  [1]                      mul/div accepted in EXE
//   md_done_i   [1]                      mul/div finished early
//   flush_i     [1]                      pipeline flush
//   fwd_sel_o   [NUM_RD*SEL_W]           per port: 0 = regfile, k+1 = stage k
//   stall_o     [1]                      hold IF..EXE
//   md_busy_o   [1]                      HI/LO result pending
//   stall_cnt_o [PERF_W]                 saturating count of stall cycles
interface fwd_hazard_sb_if #(
    parameter int NUM_FWD_STAGES = 3,
    parameter int NUM_RD         = 2,
    parameter int REG_AW         = 5,
    parameter int PERF_W         = 32
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
    logic [NUM_RD*REG_AW-1:0]         rd_addr_i;
    logic [NUM_RD-1:0]                rd_en_i;
    logic                             hilo_rd_i;
    logic [NUM_FWD_STAGES-1:0]        st_wr_i;
    logic [NUM_FWD_STAGES*REG_AW-1:0] st_dst_i;
    logic [NUM_FWD_STAGES-1:0]        st_rdy_i;
    logic                             md_start_i;
    logic                             md_done_i;
    logic                             flush_i;
    logic [NUM_RD*SEL_W-1:0]          fwd_sel_o;
    logic                             stall_o;
    logic                             md_busy_o;
    logic [PERF_W-1:0]                stall_cnt_o;
    modport master (
        output rd_addr_i, rd_en_i, hilo_rd_i, st_wr_i, st_dst_i, st_rdy_i,
               md_start_i, md_done_i, flush_i,
        input  fwd_sel_o, stall_o, md_busy_o, stall_cnt_o
    );
    modport slave (
        input  rd_addr_i, rd_en_i, hilo_rd_i, st_wr_i, st_dst_i, st_rdy_i,
               md_start_i, md_done_i, flush_i,
        output fwd_sel_o, stall_o, md_busy_o, stall_cnt_o
    );
endinterface

// File: rtl/fwd_hazard_sb.sv
// fwd_hazard_sb: EXE-stage forwarding select, data-hazard stall, HI/LO busy scoreboard and stall perf counter.
// Ports:
//   clk    clock
//   resetn asynchronous active-low reset
//   bus    fwd_hazard_sb_if.slave (register addresses, producer stage status, mul/div control in;
//          forward selects, stall, md_busy and stall counter out)
module fwd_hazard_sb #(
    parameter int NUM_FWD_STAGES = 3,
    parameter int NUM_RD         = 2,
    parameter int REG_AW         = 5,
    parameter int MD_LAT         = 32,
    parameter int PERF_W         = 32
) (
    input logic            clk,
    input logic            resetn,
    fwd_hazard_sb_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
    localparam int CNT_W = $clog2(MD_LAT + 1);
    logic [CNT_W-1:0]        r_md_cnt;
    logic [PERF_W-1:0]       r_stall_cnt;
    logic [NUM_RD*SEL_W-1:0] w_fwd_sel;
    logic [NUM_RD-1:0]       w_haz;
    logic                    w_md_busy;
    logic                    w_stall;
    // Scan from oldest to youngest so the youngest matching producer overwrites
    // the older ones; its readiness alone decides the hazard.
    always_comb begin
        w_fwd_sel = '0;
        w_haz     = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en_i[p] && bus.rd_addr_i[p*REG_AW +: REG_AW] != '0) begin
                for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
                    if (bus.st_wr_i[k] && bus.st_dst_i[k*REG_AW +: REG_AW] == bus.rd_addr_i[p*REG_AW +: REG_AW]) begin
                        w_fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        w_haz[p]                    = !bus.st_rdy_i[k];
                    end
                end
            end
        end
    end
    assign w_md_busy = r_md_cnt != '0;
    // A new mul/div while one is pending stalls, serialising the HI/LO producer.
    assign w_stall = !bus.flush_i && (|w_haz || (w_md_busy && (bus.hilo_rd_i || bus.md_start_i)));
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_md_cnt <= '0;
        end else if (bus.md_start_i && !w_stall) begin
            r_md_cnt <= CNT_W'(MD_LAT);
        end else if (bus.md_done_i || bus.flush_i) begin
            r_md_cnt <= '0;
        end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - CNT_W'(1);
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
        end
    end
    assign bus.fwd_sel_o   = w_fwd_sel;
    assign bus.stall_o     = w_stall;
    assign bus.md_busy_o   = w_md_busy;
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_fwd_hazard_sb.sv
// tb_fwd_hazard_sb: directed vector table for forwarding/hazard plus sequences for the scoreboard, flush, reset and perf counter.
module tb_fwd_hazard_sb;
    localparam int NS  = 3;
    localparam int NR  = 2;
    localparam int AW  = 5;
    localparam int PW  = 4;
    localparam int LAT = 32;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_busy;
    fwd_hazard_sb_if #(.NUM_FWD_STAGES(NS), .NUM_RD(NR), .REG_AW(AW), .PERF_W(PW)) bus();
    fwd_hazard_sb #(.NUM_FWD_STAGES(NS), .NUM_RD(NR), .REG_AW(AW), .MD_LAT(LAT), .PERF_W(PW)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [9:0]  addr;
        logic [1:0]  en;
        logic [2:0]  wr;
        logic [14:0] dst;
        logic [2:0]  rdy;
        logic [3:0]  sel;
        logic        stall;
    } vec_t;
    vec_t vecs[11];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic idle();
        bus.rd_addr_i  = '0;
        bus.rd_en_i    = '0;
        bus.hilo_rd_i  = 1'b0;
        bus.st_wr_i    = '0;
        bus.st_dst_i   = '0;
        bus.st_rdy_i   = '0;
        bus.md_start_i = 1'b0;
        bus.md_done_i  = 1'b0;
        bus.flush_i    = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic rst();
        idle();
        resetn = 1'b0;
        #3;
        resetn = 1'b1;
        tick();
    endtask
    task automatic apply(input vec_t v);
        bus.rd_addr_i = v.addr;
        bus.rd_en_i   = v.en;
        bus.st_wr_i   = v.wr;
        bus.st_dst_i  = v.dst;
        bus.st_rdy_i  = v.rdy;
    endtask
    initial begin
        //            addr           en     wr      dst {k2,k1,k0}          rdy     sel      stall
        vecs[0]  = '{{5'd0, 5'd5}, 2'b01, 3'b111, {5'd5, 5'd5, 5'd5}, 3'b111, 4'b0001, 1'b0};
        vecs[1]  = '{{5'd0, 5'd5}, 2'b01, 3'b110, {5'd5, 5'd5, 5'd5}, 3'b111, 4'b0010, 1'b0};
        vecs[2]  = '{{5'd0, 5'd5}, 2'b01, 3'b100, {5'd5, 5'd5, 5'd5}, 3'b111, 4'b0011, 1'b0};
        vecs[3]  = '{{5'd8, 5'd0}, 2'b10, 3'b011, {5'd0, 5'd8, 5'd8}, 3'b010, 4'b0100, 1'b1};
        vecs[4]  = '{{5'd8, 5'd0}, 2'b10, 3'b011, {5'd0, 5'd8, 5'd8}, 3'b011, 4'b0100, 1'b0};
        vecs[5]  = '{{5'd0, 5'd0}, 2'b11, 3'b111, {5'd0, 5'd0, 5'd0}, 3'b000, 4'b0000, 1'b0};
        vecs[6]  = '{{5'd9, 5'd9}, 2'b00, 3'b111, {5'd9, 5'd9, 5'd9}, 3'b000, 4'b0000, 1'b0};
        vecs[7]  = '{{5'd7, 5'd3}, 2'b11, 3'b111, {5'd3, 5'd7, 5'd3}, 3'b101, 4'b1001, 1'b1};
        vecs[8]  = '{{5'd4, 5'd6}, 2'b11, 3'b111, {5'd1, 5'd2, 5'd3}, 3'b000, 4'b0000, 1'b0};
        vecs[9]  = '{{5'd0, 5'd6}, 2'b01, 3'b011, {5'd6, 5'd6, 5'd6}, 3'b110, 4'b0001, 1'b1};
        vecs[10] = '{{5'd0, 5'd6}, 2'b01, 3'b010, {5'd0, 5'd6, 5'd6}, 3'b101, 4'b0010, 1'b1};
        idle();
        #12;
        resetn = 1'b1;
        tick();
        chk("rst_busy", 32'(bus.md_busy_o), 32'd0);
        chk("rst_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("vec%0d_sel", i), 32'(bus.fwd_sel_o), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_stall", i), 32'(bus.stall_o), 32'(vecs[i].stall));
        end
        rst();
        bus.md_start_i = 1'b1;
        #1;
        chk("md_start_idle_stall", 32'(bus.stall_o), 32'd0);
        tick();
        bus.md_start_i = 1'b0;
        chk("md_busy_c1", 32'(bus.md_busy_o), 32'd1);
        repeat (9) tick();
        bus.hilo_rd_i = 1'b1;
        #1;
        chk("hilo_stall_c10", 32'(bus.stall_o), 32'd1);
        bus.hilo_rd_i = 1'b0;
        repeat (5) tick();
        chk("md_busy_c15", 32'(bus.md_busy_o), 32'd1);
        bus.md_done_i = 1'b1;
        tick();
        bus.md_done_i = 1'b0;
        chk("md_busy_c16", 32'(bus.md_busy_o), 32'd0);
        bus.hilo_rd_i = 1'b1;
        #1;
        chk("hilo_release_c16", 32'(bus.stall_o), 32'd0);
        bus.hilo_rd_i = 1'b0;
        bus.md_start_i = 1'b1;
        tick();
        bus.md_start_i = 1'b0;
        repeat (4) tick();
        bus.md_start_i = 1'b1;
        #1;
        chk("md_back2back_stall", 32'(bus.stall_o), 32'd1);
        tick();
        bus.md_start_i = 1'b0;
        n_busy = 5;
        while (bus.md_busy_o && n_busy < 100) begin
            n_busy++;
            tick();
        end
        chk("md_busy_len", 32'(n_busy), 32'd32);
        bus.md_start_i = 1'b1;
        bus.md_done_i  = 1'b1;
        tick();
        bus.md_start_i = 1'b0;
        bus.md_done_i  = 1'b0;
        chk("start_beats_done", 32'(bus.md_busy_o), 32'd1);
        bus.md_done_i = 1'b1;
        tick();
        bus.md_done_i = 1'b0;
        chk("done_clears", 32'(bus.md_busy_o), 32'd0);
        rst();
        bus.md_start_i = 1'b1;
        tick();
        bus.md_start_i = 1'b0;
        repeat (2) tick();
        bus.flush_i   = 1'b1;
        bus.hilo_rd_i = 1'b1;
        #1;
        chk("flush_stall_c3", 32'(bus.stall_o), 32'd0);
        tick();
        bus.flush_i = 1'b0;
        chk("flush_busy_c4", 32'(bus.md_busy_o), 32'd0);
        chk("flush_hilo_c4", 32'(bus.stall_o), 32'd0);
        bus.hilo_rd_i = 1'b0;
        apply(vecs[3]);
        bus.flush_i = 1'b1;
        #1;
        chk("flush_loaduse_stall", 32'(bus.stall_o), 32'd0);
        chk("flush_loaduse_sel", 32'(bus.fwd_sel_o), 32'h4);
        rst();
        bus.md_start_i = 1'b1;
        tick();
        bus.md_start_i = 1'b0;
        bus.hilo_rd_i  = 1'b1;
        repeat (2) tick();
        chk("cnt_before_areset", 32'(bus.stall_cnt_o), 32'd2);
        #3;
        resetn = 1'b0;
        #1;
        chk("areset_busy", 32'(bus.md_busy_o), 32'd0);
        chk("areset_cnt", 32'(bus.stall_cnt_o), 32'd0);
        chk("areset_stall", 32'(bus.stall_o), 32'd0);
        rst();
        apply(vecs[3]);
        #1;
        chk("perf_stall", 32'(bus.stall_o), 32'd1);
        chk("perf_c0", 32'(bus.stall_cnt_o), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("perf_c%0d", i), 32'(bus.stall_cnt_o), 32'(i > 15 ? 15 : i));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_sb.md
Name: fwd_hazard_sb

Overview:
- Parametrised forwarding and hazard unit for the EXE stage. Successor to the fixed two-source MEM/WB forward mux.
- Scales to NUM_FWD_STAGES producer stages and NUM_RD read ports. Selects the youngest matching producer per port.
- Raises a stall when that producer's data is not yet valid, e.g. load data still in flight.
- Adds a HI/LO multi-cycle scoreboard (busy countdown for the mul/div unit) and a saturating stall-cycle perf counter.

Parameters:
- NUM_FWD_STAGES, 3, producer stages after EXE; index 0 = youngest (MEM).
- NUM_RD, 2, EXE read ports (rs, rt).
- REG_AW, 5, register address width.
- MD_LAT, 32, fixed HI/LO producer latency in cycles, ≥2.
- PERF_W, 32, perf counter width.
- Derived: SEL_W = $clog2(NUM_FWD_STAGES+1); CNT_W = $clog2(MD_LAT+1).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- rd_addr_i  in  NUM_RD*REG_AW  EXE source register addresses, packed, port 0 in LSBs.
- rd_en_i  in  NUM_RD  port actually reads the GPR.
- hilo_rd_i  in  1  EXE instruction reads HI or LO.
- st_wr_i  in  NUM_FWD_STAGES  stage k writes the GPR.
- st_dst_i  in  NUM_FWD_STAGES*REG_AW  stage k destination.
- st_rdy_i  in  NUM_FWD_STAGES  stage k result value is valid this cycle.
- md_start_i  in  1  mul/div accepted in EXE this cycle.
- md_done_i  in  1  mul/div unit finished early (optional).
- flush_i  in  1  pipeline flush (exception/eret).
- fwd_sel_o  out  NUM_RD*SEL_W  per port: 0 = regfile, k+1 = stage k.
- stall_o  out  1  hold IF..EXE this cycle.
- md_busy_o  out  1  HI/LO result pending.
- stall_cnt_o  out  PERF_W  cycles with stall_o=1.

Behaviour:
- Forwarding (combinational)
  - For each port p with rd_en_i[p]=1 and rd_addr_i[p]!=0: scan k = 0..NUM_FWD_STAGES-1.
  - The first k with st_wr_i[k]=1 and st_dst_i[k]==rd_addr_i[p] wins; fwd_sel_o[p] = k+1.
  - No match, rd_en_i[p]=0, or address 0: fwd_sel_o[p] = 0.
  - Older matching stages are ignored even if ready.
- Data hazard (combinational)
  - haz_p = winning stage has st_rdy_i[k]=0.
  - The stall does not fall through to an older stage or the regfile.
- HI/LO scoreboard (sequential, counter md_cnt)
  - Reset: md_cnt = 0.
  - md_start_i=1 and stall_o=0: md_cnt ← MD_LAT.
  - Else if md_done_i=1 or flush_i=1: md_cnt ← 0.
  - Else if md_cnt != 0: md_cnt ← md_cnt-1.
  - md_start_i while stall_o=1 is ignored; the instruction re-presents next cycle.
  - md_start_i and md_done_i together: start wins, counter reloads.
- md_busy_o = (md_cnt != 0). Registered-state-derived; 0 at reset.
- stall_o = OR(haz_p) | (hilo_rd_i & md_busy_o) | (md_start_i & md_busy_o).
  - The last term serialises back-to-back mul/div.
  - flush_i forces stall_o = 0 in the same cycle.
- Perf counter
  - stall_cnt_o increments on every clock edge where stall_o=1.
  - Saturates at all-ones; no wrap. Reset value 0.
  - Not cleared by flush.
- Asynchronous reset (resetn=0) clears md_cnt and stall_cnt_o immediately, mid-operation included.
  - Combinational outputs follow their inputs during reset, except stall_o terms driven by md_busy_o, which are 0.
- No X propagation: unused port fields are don't-care only when the matching rd_en_i bit is 0.

Test Plan:
- Priority: port0 addr=5; st_wr=3'b111, all st_dst=5, st_rdy=3'b111 → fwd_sel[0]=1, stall_o=0. Drop st_wr[0] → fwd_sel[0]=2.
- Load-use: port1 addr=8, st_wr[0]=1, st_dst[0]=8, st_rdy[0]=0, stage1 also writes 8 and is ready → fwd_sel[1]=1, stall_o=1. Next cycle st_rdy[0]=1 → stall_o=0.
- Zero reg: rd_addr=0, st_wr=all, st_dst=0 → fwd_sel=0, stall_o=0. Same with rd_en=0 and addr=9 matching → fwd_sel=0.
- Divider (MD_LAT=32): md_start at cycle 0 → md_busy_o=1 for cycles 1..32. hilo_rd at cycle 10 → stall_o=1. md_done_i at cycle 15 → md_busy_o=0 at cycle 16, stall released.
- Flush/reset: md_start, then flush_i at cycle 3 → md_cnt=0 next cycle, stall_o=0 during flush. Assert resetn=0 asynchronously mid-count → md_busy_o=0 and stall_cnt_o=0 before the next edge.
- Perf saturation (PERF_W=4): hold a load-use stall for 20 cycles → stall_cnt_o rises 0..15 and holds at 15.
